// File: rtl/alu_pipe_arbiter.sv
// alu_pipe_arbiter: shares one fixed-latency ALU pipeline among NREQ requesters.
// Ports: req_* (per-requester issue handshake), pipe_* (shared pipeline
// operands/result), rsp_* (per-requester response FIFO drain), clk, rst (sync,
// active-low). Optional macro ALU_PIPE_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module alu_pipe_arbiter #(
    parameter int DWIDTH    = 8,
    parameter int NREQ      = 2,
    parameter int LATENCY   = 3,
    parameter int RSP_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid_i,
    output logic [NREQ-1:0]        req_ready_o,
    input  logic [NREQ*DWIDTH-1:0] req_op1_i,
    input  logic [NREQ*DWIDTH-1:0] req_op2_i,
    output logic [DWIDTH-1:0]      pipe_op1_o,
    output logic [DWIDTH-1:0]      pipe_op2_o,
    input  logic [DWIDTH-1:0]      pipe_res_i,
    output logic [NREQ-1:0]        rsp_valid_o,
    input  logic [NREQ-1:0]        rsp_ready_i,
    output logic [NREQ*DWIDTH-1:0] rsp_data_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [CW-1:0]     credit [NREQ];
    logic [CW-1:0]     count  [NREQ];
    logic [PW-1:0]     wr_ptr [NREQ];
    logic [PW-1:0]     rd_ptr [NREQ];
    logic [DWIDTH-1:0] mem    [NREQ][RSP_DEPTH];

    logic              tag_v  [LATENCY];
    logic [IW-1:0]     tag_id [LATENCY];

    logic [NREQ-1:0]   elig;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   nonempty;
    logic [NREQ-1:0]   pop;
    logic [NREQ-1:0]   wr_en;
    logic [IW-1:0]     winner;
    logic              found;
    logic              issue;

`ifndef ALU_PIPE_ARB_FIXED_PRIO_EN
    logic [IW-1:0]     last_grant;
`endif

    // A requester may only issue when its buffer is guaranteed a free slot
    // for the result, since the pipeline cannot be stalled.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = rst && req_valid_i[i] && (credit[i] != '0);
        end
    end

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
`ifdef ALU_PIPE_ARB_FIXED_PRIO_EN
        for (int k = 0; k < NREQ; k++) begin
            if (!found && elig[k]) begin
                found  = 1'b1;
                winner = IW'(k);
            end
        end
`else
        // Search from the requester after the last winner, wrapping.
        for (int off = 1; off <= NREQ; off++) begin
            int idx;
            idx = int'(last_grant) + off;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && elig[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end
`endif
        if (found) begin
            grant[winner] = 1'b1;
        end
    end

    assign issue       = found;
    assign req_ready_o = grant;

    always_comb begin
        pipe_op1_o = '0;
        pipe_op2_o = '0;
        if (issue) begin
            pipe_op1_o = req_op1_i[int'(winner)*DWIDTH +: DWIDTH];
            pipe_op2_o = req_op2_i[int'(winner)*DWIDTH +: DWIDTH];
        end
    end

`ifndef ALU_PIPE_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant <= IW'(NREQ - 1);
        end else if (issue) begin
            last_grant <= winner;
        end
    end
`endif

    // Owner tags travel alongside the operands; the tail lines up with
    // pipe_res_i so the result can be steered to its requester.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_v[k]  <= 1'b0;
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= issue;
            tag_id[0] <= winner;
            for (int k = 1; k < LATENCY; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    always_comb begin
        rsp_data_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            nonempty[i] = rst && (count[i] != '0);
            pop[i]      = nonempty[i] && rsp_ready_i[i];
            wr_en[i]    = tag_v[LATENCY-1] && (tag_id[LATENCY-1] == IW'(i));
            if (nonempty[i]) begin
                rsp_data_o[i*DWIDTH +: DWIDTH] = mem[i][rd_ptr[i]];
            end
        end
    end

    assign rsp_valid_o = nonempty;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                credit[i] <= CW'(RSP_DEPTH);
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                case ({grant[i], pop[i]})
                    2'b10:   credit[i] <= credit[i] - 1'b1;
                    2'b01:   credit[i] <= credit[i] + 1'b1;
                    default: credit[i] <= credit[i];
                endcase
                case ({wr_en[i], pop[i]})
                    2'b10:   count[i] <= count[i] + 1'b1;
                    2'b01:   count[i] <= count[i] - 1'b1;
                    default: count[i] <= count[i];
                endcase
                if (wr_en[i]) begin
                    wr_ptr[i] <= (wr_ptr[i] == PW'(RSP_DEPTH - 1)) ?
                                 '0 : wr_ptr[i] + 1'b1;
                end
                if (pop[i]) begin
                    rd_ptr[i] <= (rd_ptr[i] == PW'(RSP_DEPTH - 1)) ?
                                 '0 : rd_ptr[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (wr_en[i]) begin
                mem[i][wr_ptr[i]] <= pipe_res_i;
            end
        end
    end

    // Credits reserve a slot at issue time, so a result never lands in a
    // full buffer.
    for (genvar g = 0; g < NREQ; g++) begin : g_chk
        a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
            !(wr_en[g] && (count[g] == CW'(RSP_DEPTH))));
    end

endmodule
